// File: rtl/game_match_ctrl.sv
// Match-level light-cycle FSM: menu, countdown, live round, per-player scoring, best-of termination.
// Latency: all outputs registered, one Clk after the causing input. No backpressure; Alive/keycode sampled every cycle.
// Optional GAME_PAUSE_EN: Esc in ROUND_ACTIVE enters HOLD; next Esc resumes through a fresh COUNTDOWN.
module game_match_ctrl #(
  parameter int          NUM_PLAYERS      = 2,
  parameter int          WIN_ROUNDS       = 3,
  parameter int          COUNTDOWN_CYCLES = 3,
  parameter logic [7:0]  START_KEY        = 8'h28,
  localparam int         PW               = $clog2(NUM_PLAYERS),
  localparam int         SW               = $clog2(WIN_ROUNDS + 1),
  localparam int         CW               = $clog2(COUNTDOWN_CYCLES + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Reset_Round,
  input  logic [7:0]                keycode,
  input  logic [NUM_PLAYERS-1:0]    Alive,
  output logic [2:0]                Game_State,
  output logic [NUM_PLAYERS*SW-1:0] Scores,
  output logic [PW-1:0]             Round_Winner,
  output logic                      Round_Draw,
  output logic [PW-1:0]             Match_Winner,
  output logic                      Round_Start,
  output logic [CW-1:0]             Countdown
);

  localparam int         AW      = $clog2(NUM_PLAYERS + 1);
  localparam logic [7:0] ESC_KEY = 8'h29;

  typedef enum logic [2:0] {
    MENU         = 3'd0,
    ROUND_PAUSED = 3'd1,
    COUNTDOWN    = 3'd2,
    ROUND_ACTIVE = 3'd3,
    ROUND_OVER   = 3'd4,
    MATCH_OVER   = 3'd5,
    HOLD         = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                prev_key_q;
  logic [NUM_PLAYERS*SW-1:0] scores_q, scores_d;
  logic [PW-1:0]             winner_q, winner_d;
  logic                      draw_q, draw_d;
  logic [PW-1:0]             match_q, match_d;
  logic                      start_q, start_d;
  logic [CW-1:0]             cd_q, cd_d;

  logic                      key_evt;
  logic [AW-1:0]             alive_cnt;
  logic [PW-1:0]             alive_idx;
  logic [SW-1:0]             win_score, win_next;

  // A held key produces exactly one event; prev_key_q clears on reset.
  assign key_evt = (keycode != 8'h00) && (prev_key_q == 8'h00);

  always_comb begin
    alive_cnt = '0;
    alive_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (Alive[i]) begin
        alive_cnt = alive_cnt + 1'b1;
        alive_idx = PW'(i);
      end
    end
  end

  assign win_score = scores_q[alive_idx*SW +: SW];
  assign win_next  = (win_score >= SW'(WIN_ROUNDS)) ? SW'(WIN_ROUNDS) : win_score + 1'b1;

  always_comb begin
    state_d  = state_q;
    scores_d = scores_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    match_d  = match_q;
    cd_d     = '0;

    case (state_q)
      MENU: begin
        if (key_evt && keycode == START_KEY) begin
          state_d  = ROUND_PAUSED;
          scores_d = '0;
          winner_d = '0;
          draw_d   = 1'b0;
          match_d  = '0;
        end
      end

      ROUND_PAUSED: begin
        if (key_evt) begin
          state_d = COUNTDOWN;
          cd_d    = CW'(COUNTDOWN_CYCLES);
        end
      end

      COUNTDOWN: begin
        if (Reset_Round) begin
          state_d = ROUND_PAUSED;
        end else if (cd_q == CW'(1)) begin
          state_d = ROUND_ACTIVE;
        end else begin
          cd_d = cd_q - 1'b1;
        end
      end

      ROUND_ACTIVE: begin
        if (Reset_Round) begin
          state_d = ROUND_PAUSED;
`ifdef GAME_PAUSE_EN
        end else if (key_evt && keycode == ESC_KEY) begin
          state_d = HOLD;
`endif
        end else if (alive_cnt == AW'(1)) begin
          scores_d[alive_idx*SW +: SW] = win_next;
          winner_d = alive_idx;
          draw_d   = 1'b0;
          if (win_next == SW'(WIN_ROUNDS)) begin
            state_d = MATCH_OVER;
            match_d = alive_idx;
          end else begin
            state_d = ROUND_OVER;
          end
        end else if (alive_cnt == '0) begin
          draw_d  = 1'b1;
          state_d = ROUND_OVER;
        end
      end

      ROUND_OVER: begin
        if (key_evt) state_d = ROUND_PAUSED;
      end

      MATCH_OVER: begin
        if (key_evt) state_d = MENU;
      end

`ifdef GAME_PAUSE_EN
      HOLD: begin
        // Resume through a full countdown so players get a restart warning.
        if (key_evt && keycode == ESC_KEY) begin
          state_d = COUNTDOWN;
          cd_d    = CW'(COUNTDOWN_CYCLES);
        end
      end
`endif

      default: state_d = MENU;
    endcase

    start_d = (state_q != ROUND_ACTIVE) && (state_d == ROUND_ACTIVE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= MENU;
      prev_key_q <= 8'h00;
      scores_q   <= '0;
      winner_q   <= '0;
      draw_q     <= 1'b0;
      match_q    <= '0;
      start_q    <= 1'b0;
      cd_q       <= '0;
    end else begin
      state_q    <= state_d;
      prev_key_q <= keycode;
      scores_q   <= scores_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      match_q    <= match_d;
      start_q    <= start_d;
      cd_q       <= cd_d;
    end
  end

  assign Game_State   = state_q;
  assign Scores       = scores_q;
  assign Round_Winner = winner_q;
  assign Round_Draw   = draw_q;
  assign Match_Winner = match_q;
  assign Round_Start  = start_q;
  assign Countdown    = cd_q;

endmodule
